// File: rtl/md_unit_pkg.sv
// Shared MDOp encodings, FSM states and operation-class helpers for md_unit.
package md_unit_pkg;
  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE = 3'd0,
    MULT    = 3'd1,
    MULTU   = 3'd2,
    DIV     = 3'd3,
    DIVU    = 3'd4,
    MTHI    = 3'd5,
    MTLO    = 3'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  function automatic logic is_mul(md_op_e op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction
endpackage

// File: rtl/md_unit_if.sv
// E-stage to multiply/divide unit handshake and HI/LO result bus.
interface md_unit_if
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  md_op_e           MDOp;
  logic             start;
  logic             Req;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output A, B, MDOp, start, Req, input busy, HI, LO);
  modport slave  (input A, B, MDOp, start, Req, output busy, HI, LO);
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: produces next shadow HI/LO values,
// including sign handling, divide-by-zero and signed-overflow cases.
module md_calc
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  md_op_e           op,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic                   sgn;
  logic [2*WIDTH-1:0]     ax, bx, prod;
  logic                   a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign sgn = (op == MULT) || (op == DIV);

  // Low 2W bits of the sign-extended product equal the true signed product.
  assign ax   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign bx   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod = ax * bx;

  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

  always_comb begin
    hi_n = '0;
    lo_n = '0;
    unique case (op)
      MULT, MULTU: {hi_n, lo_n} = prod;
      DIV, DIVU: begin
        if (b == '0) begin
          hi_n = a;
          lo_n = '1;
        end else if (op == DIV && a == MIN_NEG && b == '1) begin
          hi_n = '0;
          lo_n = a;
        end else begin
          hi_n = rem;
          lo_n = quo;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: result is computed at accept into shadow
// registers and released to HI/LO after a programmable busy period.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e        state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_s, lo_s, hi_c, lo_c, hi_r, lo_r;
  logic             accept, go_run, done;

  assign accept = md.start & ~md.Req & (state == IDLE);
  assign go_run = accept & (is_mul(md.MDOp) | is_div(md.MDOp));
  assign done   = (state == RUN) && (cnt == CW'(1));

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .a    (md.A),
    .b    (md.B),
    .op   (md.MDOp),
    .hi_n (hi_c),
    .lo_n (lo_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (go_run) state_n = RUN;
      RUN:  if (done)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    md.busy = (state == RUN);
    md.HI   = hi_r;
    md.LO   = lo_r;
  end

  // HI/LO only change on MT* accept or completion, so RUN never exposes partial results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      hi_s <= '0;
      lo_s <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (go_run) begin
        hi_s <= hi_c;
        lo_s <= lo_c;
        cnt  <= is_mul(md.MDOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end

      if (done) begin
        hi_r <= hi_s;
        lo_r <= lo_s;
      end else if (accept && md.MDOp == MTHI) begin
        hi_r <= md.A;
      end else if (accept && md.MDOp == MTLO) begin
        lo_r <= md.A;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: a cycle-indexed reference model queues the
// expected busy/HI/LO per cycle and a monitor compares them at each falling edge.
module tb_md_unit;
  import md_unit_pkg::*;

  parameter int WIDTH       = 32;
  parameter int MULT_CYCLES = 5;
  parameter int DIV_CYCLES  = 10;

  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef struct {
    int               due;
    string            name;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } exp_t;

  logic clk = 1'b1;
  logic reset;
  md_unit_if #(.WIDTH(WIDTH)) md();

  md_unit #(.WIDTH(WIDTH), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference state: committed HI/LO, values visible before the pending
  // result lands, and the first cycle in which the unit is idle again.
  logic [WIDTH-1:0] m_hi = '0, m_lo = '0, o_hi = '0, o_lo = '0;
  int               free_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        checks++;
        if (sb[i].due < cyc) begin
          errors++;
          $display("FAIL %s: check for cycle %0d not reached (now %0d)", sb[i].name, sb[i].due, cyc);
        end else if (md.busy !== sb[i].busy || md.HI !== sb[i].hi || md.LO !== sb[i].lo) begin
          errors++;
          $display("FAIL %s @%0d: got busy=%0b HI=%h LO=%h, want busy=%0b HI=%h LO=%h",
                   sb[i].name, cyc, md.busy, md.HI, md.LO, sb[i].busy, sb[i].hi, sb[i].lo);
        end
        sb.delete(i);
      end
    end
  end

  function automatic void ref_calc(input md_op_e op, input logic [WIDTH-1:0] a, b,
                                   output logic [WIDTH-1:0] hi, output logic [WIDTH-1:0] lo);
    longint          sa, sbv, sp;
    longint unsigned ua, ub, up;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    hi  = '0;
    lo  = '0;
    case (op)
      MULT:  begin sp = sa * sbv; hi = WIDTH'(sp >>> WIDTH); lo = WIDTH'(sp); end
      MULTU: begin up = ua * ub;  hi = WIDTH'(up >> WIDTH);  lo = WIDTH'(up); end
      DIV, DIVU: begin
        if (b == '0) begin
          lo = ONES;
          hi = a;
        end else if (op == DIV) begin
          lo = WIDTH'(sa / sbv);
          hi = WIDTH'(sa % sbv);
        end else begin
          lo = WIDTH'(ua / ub);
          hi = WIDTH'(ua % ub);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic push(input int due, input string nm, input logic bz,
                      input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    exp_t e;
    e.due = due; e.name = nm; e.busy = bz; e.hi = hi; e.lo = lo;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of E-stage inputs and queue everything that follows from it.
  task automatic issue(input md_op_e op, input logic [WIDTH-1:0] a, b,
                       input logic st, input logic rq, input string nm);
    int c, n;
    logic acc;
    logic [WIDTH-1:0] rh, rl;
    c = cyc;
    md.A = a; md.B = b; md.MDOp = op; md.start = st; md.Req = rq;
    acc = st && !rq && (c >= free_cyc);
    if (acc && (op == MULT || op == MULTU || op == DIV || op == DIVU)) begin
      n = (op == MULT || op == MULTU) ? MULT_CYCLES : DIV_CYCLES;
      ref_calc(op, a, b, rh, rl);
      o_hi = m_hi; o_lo = m_lo;
      m_hi = rh;   m_lo = rl;
      for (int i = 1; i <= n; i++) push(c + i, {nm, "_busy"}, 1'b1, o_hi, o_lo);
      push(c + n + 1, nm, 1'b0, m_hi, m_lo);
      free_cyc = c + n + 1;
    end else begin
      if (acc && op == MTHI) m_hi = a;
      if (acc && op == MTLO) m_lo = a;
      if (c + 1 < free_cyc) push(c + 1, nm, 1'b1, o_hi, o_lo);
      else                  push(c + 1, nm, 1'b0, m_hi, m_lo);
    end
    tick();
    md.start = 1'b0;
    md.Req   = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc < free_cyc) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due >= cyc) sb.delete(i);
    push(cyc, "reset", 1'b0, '0, '0);
    m_hi = '0; m_lo = '0; o_hi = '0; o_lo = '0;
    free_cyc = 0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return ONES;
      2:       return MINV;
      3:       return WIDTH'($urandom_range(0, 9));
      default: return WIDTH'($urandom());
    endcase
  endfunction

  initial begin
    md.A = '0; md.B = '0; md.MDOp = MD_NONE; md.start = 1'b0; md.Req = 1'b0;
    do_reset();

    issue(MULT,  WIDTH'(-2), WIDTH'(3), 1'b1, 1'b0, "mult_neg2x3");   wait_free();
    issue(MULTU, WIDTH'(-2), WIDTH'(3), 1'b1, 1'b0, "multu_neg2x3");  wait_free();
    issue(DIV,   WIDTH'(-7), WIDTH'(2), 1'b1, 1'b0, "div_neg7by2");   wait_free();
    issue(DIVU,  WIDTH'(7),  WIDTH'(2), 1'b1, 1'b0, "divu_7by2");     wait_free();
    issue(DIV,   MINV,       ONES,      1'b1, 1'b0, "div_overflow");  wait_free();
    issue(DIVU,  WIDTH'(5),  '0,        1'b1, 1'b0, "divu_by_zero");  wait_free();
    issue(MULT,  WIDTH'(3),  WIDTH'(4), 1'b1, 1'b1, "mult_flushed");
    issue(MTLO,  WIDTH'(16'h1234), '0,  1'b1, 1'b1, "mtlo_flushed");
    issue(MULT,  WIDTH'(3),  WIDTH'(4), 1'b1, 1'b0, "mult_3x4");
    tick();
    issue(DIV,   WIDTH'(9),  WIDTH'(2), 1'b1, 1'b0, "div_while_busy");
    wait_free();
    issue(MTHI,  WIDTH'(16'hABCD), '0,  1'b1, 1'b0, "mthi_first_idle");
    issue(MD_NONE, '0, '0, 1'b1, 1'b0, "none_start");
    issue(DIV,   WIDTH'(100), WIDTH'(7), 1'b1, 1'b0, "div_to_reset");
    repeat (3) tick();
    do_reset();
    issue(MULT,  WIDTH'(2),  WIDTH'(2), 1'b1, 1'b0, "mult_after_reset"); wait_free();

    for (int k = 0; k < 150; k++) begin
      md_op_e op;
      op = md_op_e'($urandom_range(0, 6));
      issue(op, rnd_val(), rnd_val(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
            $sformatf("rnd%0d_%s", k, op.name()));
      repeat ($urandom_range(0, 4)) tick();
    end

    for (int t = 0; t < 200 && sb.size() != 0; t++) tick();
    if (sb.size() != 0) begin
      errors += sb.size();
      checks += sb.size();
      $display("FAIL drain: %0d expected checks never reached", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
